// File: rtl/pixel_dispatcher_if.sv
// rtl/pixel_dispatcher_if.sv - engine-side handshake and pixel bus of the pixel dispatcher
interface pixel_dispatcher_if #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_ENGINES   = 4
);
    localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

    logic [NUM_ENGINES-1:0] eng_valid;
    logic [NUM_ENGINES-1:0] eng_ready;
    logic signed [31:0]     re_c;
    logic signed [31:0]     im_c;
    logic [XW-1:0]          x_cnt;
    logic [YW-1:0]          y_cnt;

    modport master (
        output eng_valid, re_c, im_c, x_cnt, y_cnt,
        input  eng_ready
    );

    modport slave (
        input  eng_valid, re_c, im_c, x_cnt, y_cnt,
        output eng_ready
    );
endinterface

// File: rtl/pixel_dispatcher.sv
// rtl/pixel_dispatcher.sv - raster-scan pixel source with round-robin engine dispatch (option: PIXEL_DISPATCH_CONTINUOUS_EN)
module pixel_dispatcher #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAC          = 16,
    parameter int NUM_ENGINES   = 4
) (
    input  logic               sysclk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic signed [31:0] re_start_i,
    input  logic signed [31:0] im_start_i,
    input  logic signed [31:0] step_i,
    output logic               busy_o,
    output logic               frame_done_o,
    pixel_dispatcher_if.master eng_if
);
    localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int PW = (NUM_ENGINES   > 1) ? $clog2(NUM_ENGINES)   : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_HEIGHT - 1);
    localparam logic [PW-1:0] PTR_TOP = PW'(NUM_ENGINES - 1);

    // FRAC only fixes the interpretation of the coordinates; the datapath is plain 32-bit wrap.
    if (FRAC < 0 || FRAC > 31) begin : g_bad_frac
        $error("pixel_dispatcher: FRAC out of range");
    end
    if (NUM_ENGINES < 1) begin : g_bad_engines
        $error("pixel_dispatcher: NUM_ENGINES must be >= 1");
    end

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_DISPATCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] re_c_q, re_c_d;
    logic signed [31:0] im_c_q, im_c_d;
    logic signed [31:0] re_start_q, re_start_d;
    logic signed [31:0] step_q, step_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               frame_done_q, frame_done_d;

    logic [NUM_ENGINES-1:0] grant;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          ptr_next;
    logic                   xfer;

    // Round-robin grant: first ready engine at or after the pointer, wrapping around.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        if (state_q == S_DISPATCH) begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                idx = PW'((int'(ptr_q) + k) % NUM_ENGINES);
                if (!found && eng_if.eng_ready[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

    assign xfer     = |grant;
    assign ptr_next = (grant_idx == PTR_TOP) ? '0 : grant_idx + PW'(1);

    // Next-state and pixel-walk logic; the pixel only moves when an engine takes it.
    always_comb begin
        state_d      = state_q;
        re_c_d       = re_c_q;
        im_c_d       = im_c_q;
        re_start_d   = re_start_q;
        step_d       = step_q;
        x_d          = x_q;
        y_d          = y_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_DISPATCH;
                    re_start_d = re_start_i;
                    step_d     = step_i;
                    re_c_d     = re_start_i;
                    im_c_d     = im_start_i;
                    x_d        = '0;
                    y_d        = '0;
                end
            end
            S_DISPATCH: begin
                if (xfer) begin
                    ptr_d = ptr_next;
                    if (x_q != X_LAST) begin
                        x_d    = x_q + XW'(1);
                        re_c_d = re_c_q + step_q;
                    end else if (y_q != Y_LAST) begin
                        x_d    = '0;
                        y_d    = y_q + YW'(1);
                        re_c_d = re_start_q;
                        im_c_d = im_c_q - step_q;
                    end else begin
                        frame_done_d = 1'b1;
`ifdef PIXEL_DISPATCH_CONTINUOUS_EN
                        // Roll straight into the next frame with freshly sampled viewport.
                        re_start_d = re_start_i;
                        step_d     = step_i;
                        re_c_d     = re_start_i;
                        im_c_d     = im_start_i;
                        x_d        = '0;
                        y_d        = '0;
`else
                        // Single-frame: stop and keep the last pixel visible.
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            re_c_q       <= '0;
            im_c_q       <= '0;
            re_start_q   <= '0;
            step_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            re_c_q       <= re_c_d;
            im_c_q       <= im_c_d;
            re_start_q   <= re_start_d;
            step_q       <= step_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign eng_if.eng_valid = grant;
    assign eng_if.re_c      = re_c_q;
    assign eng_if.im_c      = im_c_q;
    assign eng_if.x_cnt     = x_q;
    assign eng_if.y_cnt     = y_q;
    assign busy_o           = (state_q == S_DISPATCH);
    assign frame_done_o     = frame_done_q;
endmodule
